// File: rtl/matrix_alu_sequencer.sv
// Sequencer around the matrix ALU: fetches operand matrices, strobes them into the ALU,
// waits for the finish flag and writes the 256-bit result back to memory.
module matrix_alu_sequencer #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [7:0]        instr_opcode,
    input  logic [ADDR_W-1:0] instr_src1,
    input  logic [ADDR_W-1:0] instr_src2,
    input  logic [ADDR_W-1:0] instr_dst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [255:0]      mem_wdata,
    input  logic [255:0]      mem_rdata,
    input  logic              mem_ack,
    output logic [7:0]        alu_op,
    output logic [7:0]        alu_source2,
    output logic [255:0]      alu_mat_in,
    output logic              alu_load_m1,
    output logic              alu_load_m2,
    input  logic [255:0]      alu_mat_out,
    input  logic              alu_finish,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int unsigned CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [7:0]  OP_SCALE = 8'd3;
    localparam logic [7:0]  OP_TRANS = 8'd4;

    typedef enum logic [2:0] {StIdle, StRd1, StLd1, StRd2, StLd2, StWait, StWr} state_t;

    state_t             r_state;
    logic [7:0]         r_opcode;
    logic [ADDR_W-1:0]  r_src2;
    logic [ADDR_W-1:0]  r_dst;
    logic [7:0]         r_source2;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_mem_req;
    logic               r_mem_we;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [255:0]       r_mem_wdata;
    logic [255:0]       r_mat_in;
    logic               r_load_m1;
    logic               r_load_m2;
    logic               r_done;
    logic               r_error;

    logic w_illegal;
    logic w_single_op;

    assign w_illegal   = (instr_opcode == 8'd0) || (instr_opcode > 8'd5);
    assign w_single_op = (r_opcode == OP_SCALE) || (r_opcode == OP_TRANS);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= StIdle;
            r_opcode    <= '0;
            r_src2      <= '0;
            r_dst       <= '0;
            r_source2   <= '0;
            r_cnt       <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mat_in    <= '0;
            r_load_m1   <= 1'b0;
            r_load_m2   <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (instr_valid) begin
                        r_opcode  <= instr_opcode;
                        r_src2    <= instr_src2;
                        r_dst     <= instr_dst;
                        r_source2 <= (instr_opcode == OP_SCALE) ? instr_src2[7:0] : 8'd0;
                        if (w_illegal) begin
                            r_error <= 1'b1;
                        end else begin
                            r_state    <= StRd1;
                            r_mem_req  <= 1'b1;
                            r_mem_we   <= 1'b0;
                            r_mem_addr <= instr_src1;
                        end
                    end
                end
                StRd1, StRd2: begin
                    if (mem_ack) begin
                        r_mat_in  <= mem_rdata;
                        r_mem_req <= 1'b0;
                        r_state   <= (r_state == StRd1) ? StLd1 : StLd2;
                    end
                end
                // First LD cycle lets alu_mat_in settle; the strobe occupies the second.
                StLd1: begin
                    if (!r_load_m1) begin
                        r_load_m1 <= 1'b1;
                    end else begin
                        r_load_m1 <= 1'b0;
                        if (w_single_op) begin
                            r_state <= StWait;
                            r_cnt   <= '0;
                        end else begin
                            r_state    <= StRd2;
                            r_mem_req  <= 1'b1;
                            r_mem_addr <= r_src2;
                        end
                    end
                end
                StLd2: begin
                    if (!r_load_m2) begin
                        r_load_m2 <= 1'b1;
                    end else begin
                        r_load_m2 <= 1'b0;
                        r_state   <= StWait;
                        r_cnt     <= '0;
                    end
                end
                // A finish flag seen in the entry cycle may be stale from the previous op.
                StWait: begin
                    if ((r_cnt != '0) && alu_finish) begin
                        r_mem_wdata <= alu_mat_out;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_dst;
                        r_state     <= StWr;
                    end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        r_error <= 1'b1;
                        r_state <= StIdle;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                StWr: begin
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign instr_ready = (r_state == StIdle);
    assign busy        = (r_state != StIdle);
    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign alu_op      = r_opcode;
    assign alu_source2 = r_source2;
    assign alu_mat_in  = r_mat_in;
    assign alu_load_m1 = r_load_m1;
    assign alu_load_m2 = r_load_m2;
    assign done        = r_done;
    assign error       = r_error;

endmodule
